debounce_multi_amisha: RTL and testbench

N-channel, parametrised switch debouncer built as an explicit per-channel FSM with a down-counter.
- Each raw input is synchronised, then qualified as stable for DB_CYCLES clocks before the debounced level changes.
- Separate one-cycle rising and falling ticks are produced per channel.
- Sits between board push-buttons/slide switches and control FSMDs that need clean levels and edge events.

---
 rtl/debounce_multi_amisha.sv | 81 ++++++++
 tb/tb_debounce_multi_amisha.sv | 114 +++++++++++
 2 files changed

// File: rtl/debounce_multi_amisha.sv
// debounce_multi_amisha: N-channel switch debouncer; each channel has a synchroniser,
// a ZERO/WAIT1/ONE/WAIT0 FSM with a down-counter, and registered level, tick and busy outputs.
module debounce_multi_amisha #(
  parameter int N_CH        = 4,
  parameter int DB_CYCLES   = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_amisha,
  input  logic            reset_amisha,
  input  logic [N_CH-1:0] sw_amisha,
  output logic [N_CH-1:0] db_level_amisha,
  output logic [N_CH-1:0] rise_tick_amisha,
  output logic [N_CH-1:0] fall_tick_amisha,
  output logic [N_CH-1:0] busy_amisha,
  output logic            any_tick_amisha
);
  localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DB_CYCLES - 1);
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s;
  state_t          state   [N_CH];
  state_t          state_n [N_CH];
  logic [CW-1:0]   cnt     [N_CH];
  logic [CW-1:0]   cnt_n   [N_CH];
  assign s = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= sw_amisha;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end
  // A return to the stable level while waiting abandons the qualification silently.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    for (int i = 0; i < N_CH; i++) begin
      case (state[i])
        ZERO: if (s[i]) begin
          state_n[i] = WAIT1;
          cnt_n[i]   = RELOAD;
        end
        WAIT1: if (!s[i]) state_n[i] = ZERO;
          else if (cnt[i] == '0) state_n[i] = ONE;
          else cnt_n[i] = cnt[i] - CW'(1);
        ONE: if (!s[i]) begin
          state_n[i] = WAIT0;
          cnt_n[i]   = RELOAD;
        end
        WAIT0: if (s[i]) state_n[i] = ONE;
          else if (cnt[i] == '0) state_n[i] = ZERO;
          else cnt_n[i] = cnt[i] - CW'(1);
        default: state_n[i] = ZERO;
      endcase
    end
  end
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      for (int i = 0; i < N_CH; i++) begin
        state[i] <= ZERO;
        cnt[i]   <= '0;
      end
      db_level_amisha  <= '0;
      rise_tick_amisha <= '0;
      fall_tick_amisha <= '0;
      busy_amisha      <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      for (int i = 0; i < N_CH; i++) begin
        db_level_amisha[i]  <= state_n[i] == ONE || state_n[i] == WAIT0;
        busy_amisha[i]      <= state_n[i] == WAIT1 || state_n[i] == WAIT0;
        rise_tick_amisha[i] <= state[i] == WAIT1 && state_n[i] == ONE;
        fall_tick_amisha[i] <= state[i] == WAIT0 && state_n[i] == ZERO;
      end
    end
  end
  assign any_tick_amisha = |{rise_tick_amisha, fall_tick_amisha};
endmodule

// File: tb/tb_debounce_multi_amisha.sv
// tb_debounce_multi_amisha: table of per-edge vectors with hand-derived expectations, scoreboard-checked.
module tb_debounce_multi_amisha;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw, db, rise, fall, busy;
  logic       any;
  always #50 clk = ~clk;
  debounce_multi_amisha #(.N_CH(2), .DB_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk_amisha(clk),
    .reset_amisha(rst),
    .sw_amisha(sw),
    .db_level_amisha(db),
    .rise_tick_amisha(rise),
    .fall_tick_amisha(fall),
    .busy_amisha(busy),
    .any_tick_amisha(any)
  );
  typedef struct {
    logic       rst;
    logic [1:0] sw;
    logic [8:0] exp;
  } vec_t;
  vec_t       tbl[$];
  logic [8:0] sb[$];
  int         errors = 0;
  int         checks = 0;
  task automatic add(input int n, input logic r, input logic [1:0] s, d, ri, f, b, input logic a);
    repeat (n) tbl.push_back('{r, s, {d, ri, f, b, a}});
  endtask
  function automatic logic [8:0] got();
    return {db, rise, fall, busy, any};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (db,rise,fall,busy,any)", name, act, exp);
    end
  endtask
  initial begin
    int         n;
    logic       hit;
    logic [8:0] e;
    rst = 1'b1;
    sw  = 2'b00;
    add(2, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(2, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    // ch0 rise: busy from E+2, level and tick at E+6
    add(2, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(4, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 0);
    add(1, 0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    add(1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    add(2, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    add(4, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    // 3-sample and 4-sample bounces are both rejected
    add(2, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 0);
    add(2, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0);
    add(3, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(2, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(2, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 0);
    add(2, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0);
    add(2, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(2, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(4, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 0);
    add(1, 0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1);
    add(1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0);
    add(2, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0);
    add(4, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 0);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    // reset in WAIT1 with sw held high, then full latency from reset release
    add(2, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(2, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 0);
    add(1, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(2, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(4, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 0);
    add(1, 0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    add(1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    // glitch low while in ONE returns to ONE with no fall tick
    add(2, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    add(2, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 0);
    add(2, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst;
      sw  = tbl[i].sw;
      sb.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("row%0d", i), 32'(got()), 32'(e));
    end
    @(negedge clk);
    sw  = 2'b11;
    n   = 0;
    hit = 1'b0;
    while (n < 20 && !hit) begin
      @(posedge clk);
      #1;
      n++;
      hit = rise[1];
    end
    check("rise1_latency", 32'(n), 32'd7);
    check("rise1_tick", 32'(got()), 32'(9'b11_10_00_00_1));
    @(posedge clk);
    #1;
    check("rise1_end", 32'(got()), 32'(9'b11_00_00_00_0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
